// File: rtl/down_timer_pkg.sv
// Shared types and constants for the loadable down-counting timer.
package down_timer_pkg;

  localparam int unsigned DT_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } dt_state_e;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle between a timer user (master) and the down_timer (slave).
interface down_timer_if
  import down_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DT_WIDTH_DEFAULT
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;

  modport master (
    output en, load, load_val, start,
    input  q, busy, tc
  );

  modport slave (
    input  en, load, load_val, start,
    output q, busy, tc
  );

endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer with a one-cycle registered terminal-count pulse.
// Define DOWN_TIMER_AUTORELOAD_EN for periodic operation (reload on terminal count, stay in RUN).
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DT_WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  down_timer_if.slave   bus
);

  dt_state_e        state;
  logic [WIDTH-1:0] q_r;
  logic             busy_r;
  logic             tc_r;
`ifdef DOWN_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_r;
`endif

  // Priority: rst > load > start > count; tc defaults low so it only ever lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q_r    <= '0;
      busy_r <= 1'b0;
      tc_r   <= 1'b0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
      reload_r <= '0;
`endif
    end else begin
      tc_r <= 1'b0;
      if (bus.load) begin
        // A load aborts anything in progress; a zero value cannot be armed.
        q_r    <= bus.load_val;
        busy_r <= 1'b0;
        state  <= (bus.load_val != '0) ? ARMED : IDLE;
`ifdef DOWN_TIMER_AUTORELOAD_EN
        reload_r <= bus.load_val;
`endif
      end else begin
        case (state)
          IDLE: state <= IDLE;
          ARMED: begin
            if (bus.start && bus.en) begin
              state  <= RUN;
              busy_r <= 1'b1;
            end
          end
          RUN: begin
            if (bus.en) begin
              if (q_r == WIDTH'(1)) begin
                tc_r <= 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
                q_r  <= reload_r;
`else
                q_r    <= '0;
                busy_r <= 1'b0;
                state  <= DONE;
`endif
              end else if (q_r != '0) begin
                q_r <= q_r - WIDTH'(1);
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.q    = q_r;
  assign bus.busy = busy_r;
  assign bus.tc   = tc_r;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed vector table, corner sequences, random vs model.
module tb_down_timer;

  localparam int unsigned W = 4;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic clk;
  logic rst;

  down_timer_if #(.WIDTH(W)) bus ();

  down_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural reference: phase, remaining count and reload value as plain integers.
  int m_st = M_IDLE;
  int m_q  = 0;
  int m_rl = 0;
  bit m_tc = 1'b0;

  typedef struct {
    bit rst;
    bit en;
    bit load;
    int lv;
    bit start;
    int q;
    bit busy;
    bit tc;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit e, input bit l, input int lv, input bit s);
    bit ntc = 1'b0;
    if (r) begin
      m_st = M_IDLE; m_q = 0; m_rl = 0;
    end else if (l) begin
      m_q  = lv;
      m_rl = lv;
      m_st = (lv != 0) ? M_ARMED : M_IDLE;
    end else begin
      case (m_st)
        M_ARMED: if (s && e) m_st = M_RUN;
        M_RUN: begin
          if (e && m_q > 0) begin
            m_q = m_q - 1;
            if (m_q == 0) begin
              ntc = 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
              m_q = m_rl;
`else
              m_st = M_DONE;
`endif
            end
          end
        end
        M_DONE: m_st = M_IDLE;
        default: ;
      endcase
    end
    m_tc = ntc;
  endfunction

  // Apply one set of inputs across a rising edge, then compare all outputs with the model.
  task automatic drive(input bit r, input bit e, input bit l, input int lv, input bit s);
    rst          = r;
    bus.en       = e;
    bus.load     = l;
    bus.load_val = W'(lv);
    bus.start    = s;
    @(posedge clk);
    model_step(r, e, l, lv, s);
    #1;
    chk("q_model", int'(bus.q), m_q);
    chk("busy_model", int'(bus.busy), (m_st == M_RUN) ? 1 : 0);
    chk("tc_model", int'(bus.tc), int'(m_tc));
  endtask

  // Start a countdown and return the number of edges after the start edge until tc is seen.
  task automatic run_count(input bit do_load, input int lv, input int hold_at, input int hold_n,
                           output int lat);
    int held = 0;
    lat = -1;
    if (do_load) drive(0, 1, 1, lv, 0);
    drive(0, 1, 0, 0, 1);
    for (int k = 1; k <= 100; k++) begin
      bit e = 1'b1;
      if (m_q == hold_at && held < hold_n) begin
        e = 1'b0;
        held++;
      end
      drive(0, e, 0, 0, 0);
      if (bus.q == W'(15) && m_q == 0) chk("no_wrap", int'(bus.q), 0);
      if (bus.tc) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0;

    //           rst en ld lv st   q busy tc
    vecs[0]  = '{1, 0, 0, 0, 0,   0, 0, 0};
    vecs[1]  = '{0, 0, 1, 5, 0,   5, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 1,   5, 1, 0};
    vecs[3]  = '{0, 1, 0, 0, 0,   4, 1, 0};
    vecs[4]  = '{0, 1, 0, 0, 0,   3, 1, 0};
    vecs[5]  = '{0, 1, 0, 0, 0,   2, 1, 0};
    vecs[6]  = '{0, 1, 0, 0, 0,   1, 1, 0};
`ifdef DOWN_TIMER_AUTORELOAD_EN
    vecs[7]  = '{0, 1, 0, 0, 0,   5, 1, 1};
    vecs[8]  = '{0, 0, 1, 0, 0,   0, 0, 0};
`else
    vecs[7]  = '{0, 1, 0, 0, 0,   0, 0, 1};
    vecs[8]  = '{0, 1, 0, 0, 0,   0, 0, 0};
`endif
    vecs[9]  = '{0, 0, 1, 0, 0,   0, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 1,   0, 0, 0};
    vecs[11] = '{0, 0, 1, 2, 0,   2, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 1,   2, 0, 0};
    vecs[13] = '{0, 1, 0, 0, 1,   2, 1, 0};
    vecs[14] = '{0, 0, 0, 0, 0,   2, 1, 0};
    vecs[15] = '{0, 1, 0, 0, 0,   1, 1, 0};
`ifdef DOWN_TIMER_AUTORELOAD_EN
    vecs[16] = '{0, 1, 0, 0, 0,   2, 1, 1};
    vecs[17] = '{0, 0, 1, 7, 0,   7, 0, 0};
`else
    vecs[16] = '{0, 1, 0, 0, 0,   0, 0, 1};
    vecs[17] = '{0, 0, 1, 7, 0,   7, 0, 0};
`endif
    vecs[18] = '{1, 1, 0, 0, 1,   0, 0, 0};

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].lv, vecs[i].start);
      chk($sformatf("vec%0d_q", i), int'(bus.q), vecs[i].q);
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vecs[i].busy));
      chk($sformatf("vec%0d_tc", i), int'(bus.tc), int'(vecs[i].tc));
    end

    // Reset in the middle of a countdown; start alone afterwards must do nothing.
    drive(0, 1, 1, 9, 0);
    drive(0, 1, 0, 0, 1);
    for (int g = 0; g < 20 && m_q != 5; g++) drive(0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    chk("rst_mid_q", int'(bus.q), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_tc", int'(bus.tc), 0);
    for (int g = 0; g < 3; g++) begin
      drive(0, 1, 0, 0, 1);
      chk("post_rst_start_q", int'(bus.q), 0);
      chk("post_rst_start_busy", int'(bus.busy), 0);
    end

    // Uninterrupted vs. enable dropped for 3 cycles at q=4.
    run_count(1, 6, -1, 0, lat);
    chk("lat_6", lat, 6);
    drive(1, 0, 0, 0, 0);
    run_count(1, 6, 4, 3, lat);
    chk("lat_6_hold3", lat, 9);
    drive(1, 0, 0, 0, 0);

    // Abort by reload mid-run, then restart from the new value.
    drive(0, 1, 1, 8, 0);
    drive(0, 1, 0, 0, 1);
    for (int g = 0; g < 20 && m_q != 5; g++) drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 3, 0);
    chk("abort_q", int'(bus.q), 3);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_tc", int'(bus.tc), 0);
    run_count(0, 3, -1, 0, lat);
    chk("lat_after_abort", lat, 3);
    drive(1, 0, 0, 0, 0);

    // Maximum load value.
    run_count(1, 15, -1, 0, lat);
    chk("lat_15", lat, 15);
    drive(0, 1, 0, 0, 0);
`ifndef DOWN_TIMER_AUTORELOAD_EN
    chk("after_15_q", int'(bus.q), 0);
`endif
    drive(1, 0, 0, 0, 0);

`ifdef DOWN_TIMER_AUTORELOAD_EN
    begin
      int pulses = 0;
      int busy_cnt = 0;
      drive(0, 1, 1, 3, 0);
      drive(0, 1, 0, 0, 1);
      for (int g = 0; g < 12; g++) begin
        drive(0, 1, 0, 0, 0);
        if (bus.tc) pulses++;
        if (bus.busy) busy_cnt++;
      end
      chk("auto_pulses", pulses, 4);
      chk("auto_busy_cycles", busy_cnt, 12);
      drive(1, 0, 0, 0, 0);
    end
`endif

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      bit r = ($urandom_range(63) == 0);
      bit l = ($urandom_range(9) == 0);
      bit s = ($urandom_range(3) == 0);
      bit e = ($urandom_range(3) != 0);
      int lv = int'($urandom_range(15));
      drive(r, e, l, lv, s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
